// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: timed 4-LED pattern sequencer (BLINK/CHASE/BOUNCE/BINARY), N passes or free-run.
// All outputs registered, one step every tickMax cycles; no backpressure, i_stop aborts on the next edge.
module led_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_tickMax,
    input  logic [7:0]       i_passes,
    output logic [3:0]       o_led,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BINARY = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,    state_d;
    logic [1:0]       mode_q,     mode_d;
    logic [CNT_W-1:0] tick_max_q, tick_max_d;
    logic [7:0]       passes_q,   passes_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]       pass_cnt_q, pass_cnt_d;
    logic [3:0]       step_q,     step_d;
    logic [3:0]       led_q,      led_d;
    logic             tick_q,     tick_d;

    logic [7:0]       pass_inc;
    logic [3:0]       step_inc;
    logic             step_now;

    // LED value for a given position within one pass of the selected pattern.
    function automatic logic [3:0] pattern_at(input logic [1:0] mode, input logic [3:0] idx);
        logic [3:0] pat;
        pat = 4'b0000;
        case (mode)
            MODE_BLINK:  pat = (idx == 4'd0) ? 4'b1111 : 4'b0000;
            MODE_CHASE:  pat = 4'b0001 << idx[1:0];
            MODE_BOUNCE: begin
                case (idx)
                    4'd0:    pat = 4'b0001;
                    4'd1:    pat = 4'b0010;
                    4'd2:    pat = 4'b0100;
                    4'd3:    pat = 4'b1000;
                    4'd4:    pat = 4'b0100;
                    default: pat = 4'b0010;
                endcase
            end
            MODE_BINARY: pat = idx;
            default:     pat = 4'b0000;
        endcase
        return pat;
    endfunction

    // Index of the final step in a pass; stepping past it wraps to the start pattern.
    function automatic logic [3:0] last_step(input logic [1:0] mode);
        logic [3:0] last;
        last = 4'd0;
        case (mode)
            MODE_BLINK:  last = 4'd1;
            MODE_CHASE:  last = 4'd3;
            MODE_BOUNCE: last = 4'd5;
            MODE_BINARY: last = 4'd15;
            default:     last = 4'd0;
        endcase
        return last;
    endfunction

    assign pass_inc = pass_cnt_q + 8'd1;
    assign step_inc = step_q + 4'd1;
    assign step_now = (tick_cnt_q == (tick_max_q - CNT_ONE));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tick_max_d = tick_max_q;
        passes_d   = passes_q;
        tick_cnt_d = tick_cnt_q;
        pass_cnt_d = pass_cnt_q;
        step_d     = step_q;
        led_d      = led_q;
        tick_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                led_d = 4'b0000;
                if (i_start && !i_stop) begin
                    state_d    = ST_RUN;
                    mode_d     = i_mode;
                    // A zero period is stored as one so the step compare never underflows.
                    tick_max_d = (i_tickMax == CNT_ZERO) ? CNT_ONE : i_tickMax;
                    passes_d   = i_passes;
                    tick_cnt_d = CNT_ZERO;
                    pass_cnt_d = 8'd0;
                    step_d     = 4'd0;
                    led_d      = pattern_at(i_mode, 4'd0);
                end
            end

            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    led_d   = 4'b0000;
                end else if (step_now) begin
                    tick_cnt_d = CNT_ZERO;
                    tick_d     = 1'b1;
                    if (step_q == last_step(mode_q)) begin
                        step_d     = 4'd0;
                        pass_cnt_d = pass_inc;
                        if ((passes_q != 8'd0) && (pass_inc == passes_q)) begin
                            state_d = ST_DONE;
                            led_d   = 4'b0000;
                        end else begin
                            led_d   = pattern_at(mode_q, 4'd0);
                        end
                    end else begin
                        step_d = step_inc;
                        led_d  = pattern_at(mode_q, step_inc);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                led_d   = 4'b0000;
            end

            default: begin
                state_d = ST_IDLE;
                led_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd0;
            tick_max_q <= CNT_ONE;
            passes_q   <= 8'd0;
            tick_cnt_q <= CNT_ZERO;
            pass_cnt_q <= 8'd0;
            step_q     <= 4'd0;
            led_q      <= 4'b0000;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tick_max_q <= tick_max_d;
            passes_q   <= passes_d;
            tick_cnt_q <= tick_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            step_q     <= step_d;
            led_q      <= led_d;
            tick_q     <= tick_d;
        end
    end

    assign o_led  = led_q;
    assign o_tick = tick_q;
    assign o_busy = (state_q == ST_RUN);
    assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus randomized runs against a cycle-index model.
module tb_led_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_stop;
    logic [1:0]  i_mode;
    logic [31:0] i_tickMax;
    logic [7:0]  i_passes;
    logic [3:0]  o_led;
    logic        o_tick;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] seq_tab [4][16];
    int         seq_len [4];

    led_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_mode    (i_mode),
        .i_tickMax (i_tickMax),
        .i_passes  (i_passes),
        .o_led     (o_led),
        .o_tick    (o_tick),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_led, input logic e_tick,
                             input logic e_busy, input logic e_done);
        check(tag, "led",  o_led, e_led);
        check(tag, "tick", {3'b000, o_tick}, {3'b000, e_tick});
        check(tag, "busy", {3'b000, o_busy}, {3'b000, e_busy});
        check(tag, "done", {3'b000, o_done}, {3'b000, e_done});
    endtask

    // Cycle k counts from the first cycle after the start edge. Step s = k / T shows
    // pattern s mod L; a finite run ends after L*passes steps with one DONE cycle.
    task automatic run_seq(input int mode, input int tmax, input int passes, input int stop_at,
                           input bit scramble, input string tag);
        int         T, L, done_k, k_end;
        logic [3:0] e_led;
        logic       e_tick, e_busy, e_done;
        T      = (tmax == 0) ? 1 : tmax;
        L      = seq_len[mode];
        done_k = (passes != 0) ? L * passes * T : -1;
        if (stop_at >= 0 && done_k >= 0 && stop_at >= done_k) stop_at = -1;
        if (stop_at < 0 && done_k < 0) stop_at = 8 * T;
        k_end  = (stop_at >= 0) ? stop_at + 1 : done_k + 1;

        @(negedge clk);
        i_mode    = 2'(mode);
        i_tickMax = 32'(tmax);
        i_passes  = 8'(passes);
        i_start   = 1'b1;
        i_stop    = 1'b0;
        @(negedge clk);
        i_start   = 1'b0;

        for (int k = 0; k <= k_end; k++) begin
            if (k == k_end) begin
                e_led = 4'b0000; e_tick = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            end else if (k == done_k) begin
                e_led = 4'b0000; e_tick = 1'b1; e_busy = 1'b0; e_done = 1'b1;
            end else begin
                e_led  = seq_tab[mode][(k / T) % L];
                e_tick = (k > 0) && (k % T == 0);
                e_busy = 1'b1;
                e_done = 1'b0;
            end
            check_all(tag, e_led, e_tick, e_busy, e_done);

            if (k < k_end) begin
                i_start = 1'b0;
                i_stop  = 1'b0;
                if (scramble) begin
                    i_mode    = 2'($urandom);
                    i_tickMax = $urandom_range(0, 7);
                    i_passes  = 8'($urandom_range(0, 255));
                    i_start   = 1'($urandom_range(0, 1));
                end
                if (k == stop_at) i_stop = 1'b1;
                if (k == done_k) begin
                    i_start = 1'b1;
                    i_stop  = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end else begin
                i_start = 1'b0;
                i_stop  = 1'b0;
            end
        end
    endtask

    initial begin
        int mode, tmax, passes, stop_at;

        seq_len[0] = 2;  seq_len[1] = 4;  seq_len[2] = 6;  seq_len[3] = 16;
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 16; i++) seq_tab[m][i] = 4'b0000;
        seq_tab[0][0] = 4'b1111; seq_tab[0][1] = 4'b0000;
        for (int i = 0; i < 4; i++) seq_tab[1][i] = 4'b0001 << i;
        seq_tab[2][0] = 4'b0001; seq_tab[2][1] = 4'b0010; seq_tab[2][2] = 4'b0100;
        seq_tab[2][3] = 4'b1000; seq_tab[2][4] = 4'b0100; seq_tab[2][5] = 4'b0010;
        for (int i = 0; i < 16; i++) seq_tab[3][i] = 4'(i);

        // Reset held with start asserted: block must stay idle.
        rst = 1'b1; i_start = 1'b1; i_stop = 1'b0;
        i_mode = 2'd1; i_tickMax = 32'd3; i_passes = 8'd2;
        repeat (3) begin
            @(negedge clk);
            check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0; i_start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_all("post_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        end

        run_seq(1, 3, 2, -1, 1'b0, "chase_t3_p2");
        run_seq(2, 0, 1, -1, 1'b0, "bounce_t0_p1");
        run_seq(3, 2, 0, 39, 1'b0, "binary_stop");
        run_seq(0, 5, 3, -1, 1'b1, "blink_scramble");
        run_seq(0, 1, 0, 599, 1'b0, "blink_wrap");

        // Start and stop together in IDLE: no run.
        @(negedge clk);
        i_start = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        check_all("start_stop_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_all("start_stop_idle2", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset in mid-run discards the run; no restart without a new start.
        i_mode = 2'd1; i_tickMax = 32'd2; i_passes = 8'd0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun", "busy", {3'b000, o_busy}, 4'b0001);
        rst = 1'b1; i_start = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        check_all("midrun_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all("midrun_after", 4'b0000, 1'b0, 1'b0, 1'b0);
        end

        for (int r = 0; r < 12; r++) begin
            mode    = int'($urandom_range(0, 3));
            tmax    = int'($urandom_range(0, 4));
            passes  = int'($urandom_range(0, 3));
            stop_at = ($urandom_range(0, 1) == 1 || passes == 0) ? int'($urandom_range(0, 70)) : -1;
            run_seq(mode, tmax, passes, stop_at, 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
